// File: rtl/spi_sample_fifo_pkg.sv
// Shared constants and status layout for the SPI sample buffer.
// No logic. Constants only.
// No flow control. Constants only.
package spi_fifo_pkg;

    // data_out value presented whenever the FIFO holds nothing
    localparam logic [31:0] EMPTY_WORD = 32'h0000_0000;

    // Bit positions inside the 4-bit status nibble
    localparam int ST_OVF   = 3;
    localparam int ST_FULL  = 2;
    localparam int ST_EMPTY = 1;
    localparam int ST_ARMED = 0;

    // Bit positions of enable/clear inside the control word
    localparam int CTRL_EN  = 7;
    localparam int CTRL_CLR = 6;

    typedef struct packed {
        logic ovf;
        logic full;
        logic empty;
        logic armed;
    } status_t;

    // Assemble the read-back nibble in the documented bit order
    function automatic logic [3:0] pack_status(input logic ovf, input logic full,
                                               input logic empty, input logic armed);
        logic [3:0] s;
        s           = '0;
        s[ST_OVF]   = ovf;
        s[ST_FULL]  = full;
        s[ST_EMPTY] = empty;
        s[ST_ARMED] = armed;
        return s;
    endfunction

endpackage

// File: rtl/spi_sample_fifo_if.sv
// Sample-in and readout-side signal bundle for spi_sample_fifo.
// No latency of its own. It is wiring only.
// The producer cannot be stalled. Overflow is reported in status.
interface spi_sample_fifo_if #(
    parameter int DW = 32,
    parameter int AW = 4
);
    logic          sample_valid;
    logic [DW-1:0] sample_data;
    logic          frame_read;
    logic          frame_end;
    logic [DW-1:0] data_out;
    logic [AW:0]   count;
    logic [3:0]    status;

    // Acquisition and SPI side: drives samples and frame events
    modport master (
        output sample_valid, sample_data, frame_read, frame_end,
        input  data_out, count, status
    );

    // FIFO side: consumes samples and frame events, presents head and status
    modport slave (
        input  sample_valid, sample_data, frame_read, frame_end,
        output data_out, count, status
    );
endinterface

// File: rtl/spi_sample_fifo_regfile.sv
// Storage array for the sample FIFO. It has one write port and one combinational read port.
// Writes land on the clock edge. The read is combinational from the address.
// No flow control. The caller guarantees it never writes into a live entry.
module fifo_regfile #(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];

    // Storage is deliberately unreset. Occupancy tracking decides what is live.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/spi_sample_fifo.sv
// Decimating show-ahead sample FIFO that feeds the SPI readout register. It pops once per armed frame end.
// Latency: a push into an empty FIFO, or a pop, updates data_out after 1 clock.
// No backpressure. A kept sample that finds the FIFO full is dropped and sets sticky overflow.
module spi_sample_fifo
    import spi_fifo_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 4,
    parameter int DECIM_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               clear,
    input  logic [DECIM_W-1:0] decim,
    spi_sample_fifo_if.slave   bus
);
    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    logic [DECIM_W-1:0] dcnt;
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      wr_ptr;
    logic [AW:0]        count_q;
    logic               ovf_q;
    logic               armed_q;
    logic               full_q;
    logic               empty_q;
    logic [DW-1:0]      data_out_q;

    logic               kept;
    logic               pop;
    logic               push;
    logic [AW-1:0]      rd_ptr_nxt;
    logic [AW:0]        count_nxt;
    logic [DW-1:0]      head_nxt;
    logic [DW-1:0]      rd_data;

    fifo_regfile #(.DW(DW), .AW(AW)) u_regfile (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (bus.sample_data),
        .raddr (rd_ptr_nxt),
        .rdata (rd_data)
    );

    // Next-state decode: keep/push/pop decisions and the next head word
    always_comb begin
        kept       = enable & ~clear & bus.sample_valid & (dcnt == '0);
        pop        = bus.frame_end & armed_q & ~clear;
        // A full FIFO still accepts the sample if the head leaves this cycle
        push       = kept & ((count_q != FULL_CNT) | pop);
        rd_ptr_nxt = pop ? rd_ptr + 1'b1 : rd_ptr;

        count_nxt = count_q;
        if (push && !pop) begin
            count_nxt = count_q + 1'b1;
        end else if (pop && !push) begin
            count_nxt = count_q - 1'b1;
        end

        // The head changes only when the FIFO drains, when a pop exposes the next entry,
        // or when a sample lands in an empty FIFO
        head_nxt = data_out_q;
        if (count_nxt == '0) begin
            head_nxt = DW'(EMPTY_WORD);
        end else if (pop) begin
            // When the last entry is popped and a sample arrives in the same cycle, the new
            // head is still in flight to the array, so it is taken straight from the input
            head_nxt = (count_q == ONE_CNT) ? bus.sample_data : rd_data;
        end else if (push && (count_q == '0)) begin
            head_nxt = bus.sample_data;
        end
    end

    // Decimation counter: keep one sample when it reads zero, then reload from decim
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt <= '0;
        end else if (!enable || clear) begin
            dcnt <= '0;
        end else if (bus.sample_valid) begin
            dcnt <= (dcnt == '0) ? decim : dcnt - 1'b1;
        end
    end

    // Pointers, occupancy, flags and the head register update together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            armed_q    <= 1'b0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            data_out_q <= DW'(EMPTY_WORD);
        end else if (clear) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            armed_q    <= 1'b0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            data_out_q <= DW'(EMPTY_WORD);
        end else begin
            rd_ptr     <= rd_ptr_nxt;
            wr_ptr     <= push ? wr_ptr + 1'b1 : wr_ptr;
            count_q    <= count_nxt;
            full_q     <= (count_nxt == FULL_CNT);
            empty_q    <= (count_nxt == '0);
            data_out_q <= head_nxt;
            if (kept && !push) begin
                ovf_q <= 1'b1;
            end
            // A frame that shifts the readout register arms the next frame end, but only
            // while there is something to pop
            if (pop) begin
                armed_q <= 1'b0;
            end else if (bus.frame_read && (count_q != '0)) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.count    = count_q;
    assign bus.status   = pack_status(ovf_q, full_q, empty_q, armed_q);

endmodule

// File: tb/tb_spi_sample_fifo.sv
// Directed bench for spi_sample_fifo. The expected values are computed by hand from the behaviour description.
// Inputs change 1 time unit after the rising edge. Outputs are checked at the same point.
// The sample source is never stalled. Overflow is checked through status.
module tb_spi_sample_fifo;
    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       clear;
    logic [7:0] decim;
    int         n_chk;
    int         n_bad;

    spi_sample_fifo_if #(.DW(32), .AW(4)) bus ();

    spi_sample_fifo #(.DW(32), .AW(4), .DECIM_W(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .clear  (clear),
        .decim  (decim),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        bus.sample_valid = 1'b1;
        bus.sample_data  = d;
        tick();
        bus.sample_valid = 1'b0;
    endtask

    task automatic frame();
        bus.frame_read = 1'b1;
        tick();
        bus.frame_read = 1'b0;
        bus.frame_end  = 1'b1;
        tick();
        bus.frame_end  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_bad = 0;
        rst_n = 1'b0;
        enable = 1'b0;
        clear = 1'b0;
        decim = 8'd0;
        bus.sample_valid = 1'b0;
        bus.sample_data  = '0;
        bus.frame_read   = 1'b0;
        bus.frame_end    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_data", bus.data_out, 32'h0);
        chk("rst_count", bus.count, 5'd0);
        chk("rst_status", bus.status, 4'b0010);

        // Basic flow
        enable = 1'b1;
        push(32'h01234567);
        chk("push1_data", bus.data_out, 32'h01234567);
        chk("push1_count", bus.count, 5'd1);
        push(32'h11223344);
        chk("push2_data", bus.data_out, 32'h01234567);
        chk("push2_count", bus.count, 5'd2);
        chk("push2_status", bus.status, 4'b0000);
        frame();
        chk("pop1_data", bus.data_out, 32'h11223344);
        chk("pop1_count", bus.count, 5'd1);
        frame();
        chk("pop2_data", bus.data_out, 32'h0);
        chk("pop2_status", bus.status, 4'b0010);

        // Decimation by 4: samples 0, 4 and 8 survive
        decim = 8'd3;
        bus.sample_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.sample_data = 32'(i);
            tick();
        end
        bus.sample_valid = 1'b0;
        chk("dec_count", bus.count, 5'd3);
        chk("dec_head0", bus.data_out, 32'd0);
        frame();
        chk("dec_head1", bus.data_out, 32'd4);
        frame();
        chk("dec_head2", bus.data_out, 32'd8);
        frame();
        chk("dec_empty", bus.status, 4'b0010);
        decim = 8'd0;

        // Fill to full, then overflow
        for (int i = 0; i < 16; i++) push(32'hA000_0000 + 32'(i));
        chk("full_count", bus.count, 5'd16);
        chk("full_status", bus.status, 4'b0100);
        push(32'h0000_0BAD);
        chk("ovf_count", bus.count, 5'd16);
        chk("ovf_status", bus.status, 4'b1100);
        chk("ovf_head", bus.data_out, 32'hA000_0000);

        // Push and pop in the same cycle while full
        bus.frame_read = 1'b1;
        tick();
        bus.frame_read = 1'b0;
        chk("armed_status", bus.status, 4'b1101);
        bus.sample_valid = 1'b1;
        bus.sample_data  = 32'hC0FF_EE00;
        bus.frame_end    = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
        bus.frame_end    = 1'b0;
        chk("pp_count", bus.count, 5'd16);
        chk("pp_head", bus.data_out, 32'hA000_0001);
        chk("pp_status", bus.status, 4'b1100);
        for (int i = 0; i < 14; i++) frame();
        chk("drain_head", bus.data_out, 32'hA000_000F);
        chk("drain_count", bus.count, 5'd2);
        frame();
        chk("tail_head", bus.data_out, 32'hC0FF_EE00);
        chk("tail_count", bus.count, 5'd1);

        // An unarmed frame end at count 5 is ignored
        for (int i = 0; i < 4; i++) push(32'hD000_0000 + 32'(i));
        chk("pre_unarm_count", bus.count, 5'd5);
        bus.frame_end = 1'b1;
        tick();
        bus.frame_end = 1'b0;
        chk("unarm_count", bus.count, 5'd5);
        chk("unarm_head", bus.data_out, 32'hC0FF_EE00);

        // Clear with count 7 and overflow set
        push(32'hD000_0004);
        push(32'hD000_0005);
        chk("pre_clr_count", bus.count, 5'd7);
        chk("pre_clr_status", bus.status, 4'b1000);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_count", bus.count, 5'd0);
        chk("clr_status", bus.status, 4'b0010);
        chk("clr_data", bus.data_out, 32'h0);

        // A frame read while empty must not arm
        bus.frame_read = 1'b1;
        tick();
        bus.frame_read = 1'b0;
        chk("empty_rd_status", bus.status, 4'b0010);
        push(32'hE000_0001);
        bus.frame_end = 1'b1;
        tick();
        bus.frame_end = 1'b0;
        chk("empty_rd_count", bus.count, 5'd1);
        chk("empty_rd_head", bus.data_out, 32'hE000_0001);

        // Asynchronous reset between edges, mid-fill
        push(32'hE000_0002);
        chk("pre_rst_count", bus.count, 5'd2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_data", bus.data_out, 32'h0);
        chk("arst_count", bus.count, 5'd0);
        chk("arst_status", bus.status, 4'b0010);
        #2;
        rst_n = 1'b1;
        tick();
        bus.frame_end = 1'b1;
        tick();
        bus.frame_end = 1'b0;
        chk("post_rst_count", bus.count, 5'd0);
        chk("post_rst_status", bus.status, 4'b0010);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
